// File: rtl/lcd_bus_ctrl.sv
// HD44780-style LCD bus sequencer: power-up wait, fixed init
// sequence, then request-driven byte writes with full bus timing.
module lcd_bus_ctrl #(
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned SETUP_CYC     = 25,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 25,
  parameter int unsigned CMD_WAIT_CYC  = 2500,
  parameter int unsigned LONG_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] data,
  output logic       RS,
  output logic       RW,
  output logic       EN
);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [1:0]  idx;
  logic [1:0]  idx_n;
  logic        done_n;
  logic [7:0]  init_cmd;
  logic [31:0] wait_len;
  logic        accept;

  assign req_ready = (state == S_IDLE) && init_done;
  assign busy      = (state != S_IDLE);
  assign RW        = 1'b0;
  assign accept    = req_valid && req_ready;

  // Clear and Return Home need the long execution time
  assign wait_len = (!RS && data[7:2] == 6'd0) ?
                    LONG_WAIT_CYC : CMD_WAIT_CYC;

  always_comb begin
    init_cmd = 8'h38;
    unique case (idx)
      2'd0: init_cmd = 8'h38;
      2'd1: init_cmd = 8'h0C;
      2'd2: init_cmd = 8'h01;
      2'd3: init_cmd = 8'h06;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = init_done;
    unique case (state)
      S_POWERUP: begin
        if (cnt == POWERUP_CYC - 1) begin
          state_n = S_INIT_LOAD;
          idx_n   = 2'd0;
        end
      end
      S_INIT_LOAD: state_n = S_SETUP;
      S_SETUP: begin
        if (cnt == SETUP_CYC - 1)
          state_n = S_PULSE;
      end
      S_PULSE: begin
        if (cnt == EN_CYC - 1)
          state_n = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == HOLD_CYC - 1)
          state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == wait_len - 1) begin
          if (init_done) begin
            state_n = S_IDLE;
          end else if (idx == 2'd3) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_INIT_LOAD;
            idx_n   = idx + 2'd1;
          end
        end
      end
      S_IDLE: begin
        if (accept)
          state_n = S_SETUP;
      end
      default: state_n = S_POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_POWERUP;
      cnt       <= '0;
      idx       <= '0;
      init_done <= 1'b0;
      data      <= 8'h00;
      RS        <= 1'b0;
      EN        <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= (state_n != state) ? '0 : cnt + 32'd1;
      idx       <= idx_n;
      init_done <= done_n;
      // registered from next state so EN is glitch-free
      EN        <= (state_n == S_PULSE);
      if (state == S_INIT_LOAD) begin
        data <= init_cmd;
        RS   <= 1'b0;
      end else if (accept) begin
        data <= req_data;
        RS   <= req_rs;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl with shortened timing parameters.
// Samples on the falling edge, drives on the falling edge.
module tb_lcd_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       init_done;
  logic       busy;
  logic [7:0] data;
  logic       RS;
  logic       RW;
  logic       EN;

  int checks = 0;
  int fails  = 0;

  lcd_bus_ctrl #(
    .POWERUP_CYC  (20),
    .SETUP_CYC    (2),
    .EN_CYC       (4),
    .HOLD_CYC     (2),
    .CMD_WAIT_CYC (10),
    .LONG_WAIT_CYC(40)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs   (req_rs),
    .req_data (req_data),
    .init_done(init_done),
    .busy     (busy),
    .data     (data),
    .RS       (RS),
    .RW       (RW),
    .EN       (EN)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic rise_wait(output int n);
    bit found = 0;
    n = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      n++;
      if (EN === 1'b1) found = 1;
    end
    if (!found) n = -1;
  endtask

  task automatic ready_wait(output int n);
    bit found = 0;
    n = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      n++;
      if (req_ready === 1'b1) found = 1;
    end
    if (!found) n = -1;
  endtask

  task automatic pulse_len(output int n, output bit stable);
    logic [7:0] d0;
    logic       r0;
    bit         done = 0;
    d0 = data;
    r0 = RS;
    n = 1;
    stable = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (data !== d0 || RS !== r0) stable = 0;
      if (EN !== 1'b1) done = 1;
      else n++;
    end
  endtask

  task automatic xfer(input logic rs, input logic [7:0] d,
                      output int rise_n, output int pls_n,
                      output int rdy_n, output bit lat_ok,
                      output bit stable);
    int tmp;
    if (req_ready !== 1'b1) ready_wait(tmp);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = 8'hFF;
    lat_ok = (data === d) && (RS === rs) &&
             (req_ready === 1'b0) && (busy === 1'b1);
    rise_wait(rise_n);
    pulse_len(pls_n, stable);
    ready_wait(rdy_n);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({EN, RS, RW, data} !== 11'd0) begin
      fails++;
      $display("FAIL reset_bus: EN=%b RS=%b RW=%b data=%h want 0",
               EN, RS, RW, data);
    end
    checks++;
    if ({req_ready, init_done, busy} !== 3'b001) begin
      fails++;
      $display("FAIL reset_ctl: ready=%b done=%b busy=%b want 0 0 1",
               req_ready, init_done, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [7:0] cmds [4];
    int gaps [3];
    int n;
    bit st;
    cmds[0] = 8'h38; cmds[1] = 8'h0C;
    cmds[2] = 8'h01; cmds[3] = 8'h06;
    gaps[0] = 15; gaps[1] = 15; gaps[2] = 45;
    rise_wait(n);
    checks++;
    if (n !== 23) begin
      fails++;
      $display("FAIL powerup_len: got %0d want 23", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data !== cmds[i] || RS !== 1'b0 || init_done !== 1'b0) begin
        fails++;
        $display("FAIL init_cmd%0d: data=%h RS=%b done=%b want %h 0 0",
                 i, data, RS, init_done, cmds[i]);
      end
      pulse_len(n, st);
      checks++;
      if (n !== 4 || !st) begin
        fails++;
        $display("FAIL init_pulse%0d: width=%0d stable=%0b want 4 1",
                 i, n, st);
      end
      if (i < 3) begin
        rise_wait(n);
        checks++;
        if (n !== gaps[i]) begin
          fails++;
          $display("FAIL init_gap%0d: got %0d want %0d",
                   i, n, gaps[i]);
        end
      end
    end
    n = 0;
    for (int i = 0; i < 300 && init_done !== 1'b1; i++) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 12 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL init_done: cyc=%0d ready=%b busy=%b want 12 1 0",
               n, req_ready, busy);
    end
  endtask

  task automatic test_char();
    int r, p, q;
    bit lat, st;
    xfer(1'b1, 8'h35, r, p, q, lat, st);
    checks++;
    if (!lat) begin
      fails++;
      $display("FAIL char_accept: data=%h RS=%b want 35 1", data, RS);
    end
    checks++;
    if (r !== 2 || p !== 4 || !st) begin
      fails++;
      $display("FAIL char_pulse: rise=%0d width=%0d stable=%0b want 2 4 1",
               r, p, st);
    end
    checks++;
    if (r + p + q !== 18) begin
      fails++;
      $display("FAIL char_busy: got %0d want 18", r + p + q);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit held;
    if (req_ready !== 1'b1) ready_wait(n);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h31;
    @(negedge clk);
    checks++;
    if (data !== 8'h31 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: data=%h busy=%b want 31 1", data, busy);
    end
    req_data = 8'h32;
    n = 0;
    held = 1;
    for (int i = 0; i < 300 && req_ready !== 1'b1; i++) begin
      @(negedge clk);
      n++;
      if (data !== 8'h31) held = 0;
    end
    checks++;
    if (n !== 18 || !held) begin
      fails++;
      $display("FAIL b2b_busy1: cyc=%0d held=%0b want 18 1", n, held);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || data !== 8'h32) begin
      fails++;
      $display("FAIL b2b_second: ready=%b data=%h want 0 32",
               req_ready, data);
    end
    req_valid = 1'b0;
    ready_wait(n);
    checks++;
    if (n !== 18) begin
      fails++;
      $display("FAIL b2b_busy2: got %0d want 18", n);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || data !== 8'h32) begin
      fails++;
      $display("FAIL b2b_idle: ready=%b data=%h want 1 32",
               req_ready, data);
    end
  endtask

  task automatic test_cmds();
    logic [7:0] c [3];
    int tot [3];
    int r, p, q;
    bit lat, st;
    c[0] = 8'h01; c[1] = 8'h02; c[2] = 8'hC0;
    tot[0] = 48; tot[1] = 48; tot[2] = 18;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, c[i], r, p, q, lat, st);
      checks++;
      if (!lat || r + p + q !== tot[i] || p !== 4) begin
        fails++;
        $display("FAIL cmd_%h: busy=%0d width=%0d lat=%0b want %0d 4 1",
                 c[i], r + p + q, p, lat, tot[i]);
      end
    end
  endtask

  task automatic test_powerup_stall();
    int rises = 0;
    int bad = 0;
    int early = 0;
    int n;
    logic prev = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h41;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 500 && init_done !== 1'b1; i++) begin
      @(negedge clk);
      if (EN === 1'b1 && prev === 1'b0) begin
        rises++;
        if (data === 8'h41) bad++;
      end
      if (req_ready === 1'b1 && init_done !== 1'b1) early++;
      prev = EN;
    end
    checks++;
    if (rises !== 4 || bad !== 0 || early !== 0 || req_ready !== 1'b1)
    begin
      fails++;
      $display("FAIL stall_init: rises=%0d bad=%0d early=%0d ready=%b",
               rises, bad, early, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (data !== 8'h41 || RS !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stall_accept: data=%h RS=%b busy=%b want 41 1 1",
               data, RS, busy);
    end
    ready_wait(n);
    rises = 0;
    prev = EN;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (EN === 1'b1 && prev === 1'b0) rises++;
      prev = EN;
    end
    checks++;
    if (n !== 18 || rises !== 0) begin
      fails++;
      $display("FAIL stall_single: busy=%0d extra=%0d want 18 0",
               n, rises);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    if (req_ready !== 1'b1) ready_wait(n);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h48;
    @(negedge clk);
    req_valid = 1'b0;
    rise_wait(n);
    checks++;
    if (n !== 2 || data !== 8'h48) begin
      fails++;
      $display("FAIL mid_pulse: rise=%0d data=%h want 2 48", n, data);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (EN !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0 ||
        data !== 8'h00 || RS !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: EN=%b busy=%b done=%b data=%h RS=%b",
               EN, busy, init_done, data, RS);
    end
    rst_n = 1'b1;
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_char();
    test_back_to_back();
    test_cmds();
    test_powerup_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
